// File: rtl/lsu_pkg.sv
// Shared types, size masks and load-extension helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_func3_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } st_func3_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } lsu_state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return MASK_B;
      2'b01:   return MASK_H;
      default: return MASK_W;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Stores only have the signed-looking encodings; the unsigned ones are load-only.
  function automatic logic func3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b100, 3'b101:         return !is_store;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extend_lane(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      LB:      return {{24{raw[7]}}, raw[7:0]};
      LH:      return {{16{raw[15]}}, raw[15:0]};
      LBU:     return {24'd0, raw[7:0]};
      LHU:     return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-stage request, memory bus and load-result signals of the load/store unit.
interface lsu_if;
  logic        req_valid;
  logic        req_load;
  logic        req_store;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        fault;

  modport slave (
    input  req_valid, req_load, req_store, req_func3, req_addr, req_wdata, mem_rdata,
    output stall, mem_addr, mem_read, mem_write, mem_wstrb, mem_wdata, ld_valid, ld_data, fault
  );

  modport master (
    output req_valid, req_load, req_store, req_func3, req_addr, req_wdata, mem_rdata,
    input  stall, mem_addr, mem_read, mem_write, mem_wstrb, mem_wdata, ld_valid, ld_data, fault
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane placement for stores and extraction/extension for loads.
// Both halves of a split access are views of one 64-bit window {hi_word, lo_word}.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  off,
  input  logic        hi_phase,
  input  logic [31:0] st_data,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_ext
);

  logic [7:0]  strb8;
  logic [63:0] wdata64;
  logic [31:0] ld_raw;

  assign strb8   = {4'd0, size_mask(func3[1:0])} << off;
  assign wdata64 = {32'd0, st_data} << {off, 3'b000};
  assign wstrb   = hi_phase ? strb8[7:4] : strb8[3:0];
  assign wdata   = hi_phase ? wdata64[63:32] : wdata64[31:0];

  assign ld_raw  = 32'({hi_word, lo_word} >> {off, 3'b000});
  assign ld_ext  = extend_lane(ld_raw, func3);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit control: fault checks, word-crossing split FSM and load result registers.
// Build option MISALIGN_TRAP_EN: word-crossing accesses fault instead of splitting.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 40
) (
  input  logic  clk,
  input  logic  rst_n,
  lsu_if.slave  bus
);

  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  lsu_state_e  state_q, state_d;
  logic [29:0] word_p0, word_nxt_p0;
  logic [1:0]  off_p0;
  logic        split_p0, mem_op_p0, range_bad_p0, fault_p0, go_p0;
  logic        mis_fault, split_en, in_split, ld_fire;

  logic [29:0] word_hi_p1;
  logic [1:0]  off_p1;
  logic [2:0]  func3_p1;
  logic [31:0] wdata_p1, lo_word_p1;
  logic        load_p1;

  logic        ld_vld_p1, fault_p1;
  logic [31:0] ld_data_p1;

  logic [2:0]  al_func3;
  logic [1:0]  al_off;
  logic [31:0] al_st, al_lo, al_hi, al_wdata, al_ld;
  logic [3:0]  al_wstrb;

  // Stage p0: request decode and fault classification
  assign word_p0     = bus.req_addr[31:2];
  assign off_p0      = bus.req_addr[1:0];
  assign word_nxt_p0 = word_p0 + 30'd1;
  assign split_p0    = ({1'b0, off_p0} + size_bytes(bus.req_func3[1:0])) > 3'd4;
  assign mem_op_p0   = bus.req_valid && (bus.req_load || bus.req_store);

`ifdef MISALIGN_TRAP_EN
  assign mis_fault = split_p0;
  assign split_en  = 1'b0;
`else
  assign mis_fault = 1'b0;
  assign split_en  = 1'b1;
`endif

  assign range_bad_p0 = ({2'b00, word_p0} >= DEPTH_L) ||
                        (split_p0 && ({2'b00, word_nxt_p0} >= DEPTH_L));
  assign fault_p0 = mem_op_p0 && ((bus.req_load && bus.req_store) ||
                                  !func3_legal(bus.req_func3, bus.req_store) ||
                                  range_bad_p0 || mis_fault);
  assign go_p0    = mem_op_p0 && !fault_p0;

  assign in_split = (state_q == SPLIT);
  assign al_func3 = in_split ? func3_p1 : bus.req_func3;
  assign al_off   = in_split ? off_p1 : off_p0;
  assign al_st    = in_split ? wdata_p1 : bus.req_wdata;
  assign al_lo    = in_split ? lo_word_p1 : bus.mem_rdata;
  assign al_hi    = in_split ? bus.mem_rdata : 32'd0;

  lsu_align u_align (
    .func3    (al_func3),
    .off      (al_off),
    .hi_phase (in_split),
    .st_data  (al_st),
    .lo_word  (al_lo),
    .hi_word  (al_hi),
    .wstrb    (al_wstrb),
    .wdata    (al_wdata),
    .ld_ext   (al_ld)
  );

  always_comb begin
    state_d       = state_q;
    ld_fire       = 1'b0;
    bus.stall     = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_wstrb = 4'd0;
    bus.mem_wdata = 32'd0;
    case (state_q)
      IDLE: begin
        if (go_p0) begin
          bus.mem_addr  = {2'b00, word_p0};
          bus.mem_read  = bus.req_load;
          bus.mem_write = bus.req_store;
          if (bus.req_store) begin
            bus.mem_wstrb = al_wstrb;
            bus.mem_wdata = al_wdata;
          end
          if (split_p0 && split_en) begin
            bus.stall = 1'b1;
            state_d   = SPLIT;
          end else begin
            ld_fire = bus.req_load;
          end
        end
      end
      SPLIT: begin
        bus.mem_addr  = {2'b00, word_hi_p1};
        bus.mem_read  = load_p1;
        bus.mem_write = !load_p1;
        if (!load_p1) begin
          bus.mem_wstrb = al_wstrb;
          bus.mem_wdata = al_wdata;
        end
        ld_fire = load_p1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Memory side stays quiet while reset is held, whatever upstream presents.
    if (!rst_n) begin
      bus.stall     = 1'b0;
      bus.mem_addr  = 32'd0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_wstrb = 4'd0;
      bus.mem_wdata = 32'd0;
    end
  end

  // Stage p1: FSM state, load result and fault pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ld_vld_p1  <= 1'b0;
      ld_data_p1 <= 32'd0;
      fault_p1   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_vld_p1 <= ld_fire;
      fault_p1  <= !in_split && fault_p0;
      if (ld_fire) ld_data_p1 <= al_ld;
    end
  end

  always_ff @(posedge clk) begin
    if (!in_split && state_d == SPLIT) begin
      word_hi_p1 <= word_nxt_p0;
      off_p1     <= off_p0;
      func3_p1   <= bus.req_func3;
      wdata_p1   <= bus.req_wdata;
      load_p1    <= bus.req_load;
      lo_word_p1 <= bus.mem_rdata;
    end
  end

  assign bus.ld_valid = ld_vld_p1;
  assign bus.ld_data  = ld_data_p1;
  assign bus.fault    = fault_p1;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl with a 40-word memory model and a load-result scoreboard.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int DEPTH = 40;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_if bus ();

  lsu_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [DEPTH];
  logic [5:0]  mem_idx;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          w2_reads = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;

  assign mem_idx       = bus.mem_addr[5:0];
  assign bus.mem_rdata = (bus.mem_addr < 32'(DEPTH)) ? mem[mem_idx] : 32'd0;

  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_addr < 32'(DEPTH)) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wstrb[b]) mem[mem_idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    if (bus.mem_read && bus.mem_addr == 32'd2) w2_reads <= w2_reads + 1;
  end

  // Scoreboard: every load result is matched against the oldest pushed expectation.
  always @(negedge clk) begin
    if (rst_n && bus.ld_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL ld_unexpected: ld_valid with data %08h, none expected", bus.ld_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (bus.ld_data !== exp_v)
          $display("FAIL ld_data: got %08h expected %08h", bus.ld_data, exp_v);
        else n_pass++;
      end
    end
  end

  task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid = v;
    bus.req_load  = ld;
    bus.req_store = st;
    bus.req_func3 = f3;
    bus.req_addr  = a;
    bus.req_wdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, LW, 32'h8, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.stall, bus.mem_read, bus.mem_write} !== 3'b000 || bus.mem_addr !== 32'd0)
      $display("FAIL reset_mem: stall/rd/wr=%b%b%b addr=%0d expected 000 addr 0",
               bus.stall, bus.mem_read, bus.mem_write, bus.mem_addr);
    else n_pass++;
    n_checks++;
    if (bus.ld_valid !== 1'b0 || bus.ld_data !== 32'd0 || bus.fault !== 1'b0)
      $display("FAIL reset_regs: ld_valid=%b ld_data=%08h fault=%b expected all 0",
               bus.ld_valid, bus.ld_data, bus.fault);
    else n_pass++;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_lw_aligned();
    mem[2] = 32'hDEADBEEF;
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, LW, 32'h8, 32'd0);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    n_checks++;
    if (bus.stall !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_addr !== 32'd2)
      $display("FAIL lw_issue: stall=%b rd=%b addr=%0d expected 0 1 2",
               bus.stall, bus.mem_read, bus.mem_addr);
    else n_pass++;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    n_checks++;
    if (bus.ld_valid !== 1'b1 || bus.stall !== 1'b0)
      $display("FAIL lw_latency: ld_valid=%b stall=%b expected 1 0", bus.ld_valid, bus.stall);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_extend();
    logic [2:0]  f3_t  [5] = '{LB, LBU, LH, LHU, LB};
    logic [31:0] adr_t [5] = '{32'h7, 32'h7, 32'h6, 32'h6, 32'h4};
    logic [31:0] exp_t [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011,
                               32'h00000033};
    mem[1] = 32'h80112233;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, f3_t[i], adr_t[i], 32'd0);
      exp_q.push_back(exp_t[i]);
      @(negedge clk);
      n_checks++;
      if (bus.mem_addr !== 32'd1 || bus.stall !== 1'b0 || bus.mem_read !== 1'b1)
        $display("FAIL ext_issue[%0d]: addr=%0d stall=%b rd=%b expected 1 0 1",
                 i, bus.mem_addr, bus.stall, bus.mem_read);
      else n_pass++;
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      n_checks++;
      if (bus.ld_valid !== 1'b1)
        $display("FAIL ext_valid[%0d]: ld_valid=%b expected 1", i, bus.ld_valid);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_split_load();
    mem[1] = 32'h44332211;
    mem[2] = 32'h88776655;
    drive(1'b1, 1'b1, 1'b0, LW, 32'h6, 32'd0);
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    n_checks++;
    if (bus.stall !== 1'b0 || bus.mem_read !== 1'b0)
      $display("FAIL trap_issue: stall=%b rd=%b expected 0 0", bus.stall, bus.mem_read);
    else n_pass++;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    n_checks++;
    if (bus.fault !== 1'b1 || bus.ld_valid !== 1'b0)
      $display("FAIL trap_fault: fault=%b ld_valid=%b expected 1 0", bus.fault, bus.ld_valid);
    else n_pass++;
`else
    exp_q.push_back(32'h66554433);
    @(negedge clk);
    n_checks++;
    if (bus.stall !== 1'b1 || bus.mem_read !== 1'b1 || bus.mem_addr !== 32'd1)
      $display("FAIL split_ld_lo: stall=%b rd=%b addr=%0d expected 1 1 1",
               bus.stall, bus.mem_read, bus.mem_addr);
    else n_pass++;
    next_cycle();
    n_checks++;
    if (bus.ld_valid !== 1'b0)
      $display("FAIL split_ld_early: ld_valid=%b expected 0", bus.ld_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.stall !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_addr !== 32'd2)
      $display("FAIL split_ld_hi: stall=%b rd=%b addr=%0d expected 0 1 2",
               bus.stall, bus.mem_read, bus.mem_addr);
    else n_pass++;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    n_checks++;
    if (bus.ld_valid !== 1'b1)
      $display("FAIL split_ld_valid: ld_valid=%b expected 1", bus.ld_valid);
    else n_pass++;
`endif
    next_cycle();
  endtask

  task automatic test_store();
    mem[0] = 32'd0;
    mem[1] = 32'd0;
    drive(1'b1, 1'b0, 1'b1, SB, 32'h5, 32'h000000EE);
    @(negedge clk);
    n_checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_wstrb !== 4'b0010 || bus.mem_wdata[15:8] !== 8'hEE)
      $display("FAIL sb_lane: wr=%b strb=%b lane1=%02h expected 1 0010 ee",
               bus.mem_write, bus.mem_wstrb, bus.mem_wdata[15:8]);
    else n_pass++;
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, SH, 32'h3, 32'h0000ABCD);
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    n_checks++;
    if (bus.mem_write !== 1'b0 || bus.stall !== 1'b0)
      $display("FAIL trap_sh: wr=%b stall=%b expected 0 0", bus.mem_write, bus.stall);
    else n_pass++;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    n_checks++;
    if (bus.fault !== 1'b1)
      $display("FAIL trap_sh_fault: fault=%b expected 1", bus.fault);
    else n_pass++;
`else
    @(negedge clk);
    n_checks++;
    if (bus.mem_addr !== 32'd0 || bus.mem_wstrb !== 4'b1000 ||
        bus.mem_wdata[31:24] !== 8'hCD || bus.stall !== 1'b1)
      $display("FAIL sh_lo: addr=%0d strb=%b lane3=%02h stall=%b expected 0 1000 cd 1",
               bus.mem_addr, bus.mem_wstrb, bus.mem_wdata[31:24], bus.stall);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.mem_addr !== 32'd1 || bus.mem_wstrb !== 4'b0001 ||
        bus.mem_wdata[7:0] !== 8'hAB || bus.stall !== 1'b0 || bus.mem_write !== 1'b1)
      $display("FAIL sh_hi: addr=%0d strb=%b lane0=%02h stall=%b wr=%b expected 1 0001 ab 0 1",
               bus.mem_addr, bus.mem_wstrb, bus.mem_wdata[7:0], bus.stall, bus.mem_write);
    else n_pass++;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    n_checks++;
    if (mem[0] !== 32'hCD000000 || mem[1] !== 32'h0000EEAB)
      $display("FAIL sh_mem: word0=%08h word1=%08h expected cd000000 0000eeab", mem[0], mem[1]);
    else n_pass++;
`endif
    next_cycle();
  endtask

  task automatic test_reset_in_split();
`ifndef MISALIGN_TRAP_EN
    mem[2]   = 32'h88776655;
    w2_reads = 0;
    drive(1'b1, 1'b1, 1'b0, LW, 32'h6, 32'd0);
    @(negedge clk);
    n_checks++;
    if (bus.stall !== 1'b1)
      $display("FAIL rs_stall: stall=%b expected 1", bus.stall);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_addr !== 32'd0 || bus.stall !== 1'b0)
      $display("FAIL rs_quiet: rd=%b addr=%0d stall=%b expected 0 0 0",
               bus.mem_read, bus.mem_addr, bus.stall);
    else n_pass++;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    rst_n = 1'b1;
    next_cycle();
    n_checks++;
    if (bus.ld_valid !== 1'b0 || w2_reads != 0)
      $display("FAIL rs_no_hi: ld_valid=%b word2 reads=%0d expected 0 0", bus.ld_valid, w2_reads);
    else n_pass++;
    drive(1'b1, 1'b1, 1'b0, LW, 32'h8, 32'd0);
    exp_q.push_back(32'h88776655);
    @(negedge clk);
    n_checks++;
    if (bus.stall !== 1'b0 || bus.mem_addr !== 32'd2 || bus.mem_read !== 1'b1)
      $display("FAIL rs_idle: stall=%b addr=%0d rd=%b expected 0 2 1",
               bus.stall, bus.mem_addr, bus.mem_read);
    else n_pass++;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    next_cycle();
`endif
  endtask

  task automatic test_fault();
    logic        ld_t  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        st_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  f3_t  [5] = '{LW, LW, 3'b011, LW, LW};
    logic [31:0] adr_t [5] = '{32'hA0, 32'h8, 32'h8, 32'h9E, 32'h8};
    logic        ef_t  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ld_t[i], st_t[i], f3_t[i], adr_t[i], 32'h12345678);
      @(negedge clk);
      n_checks++;
      if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.stall !== 1'b0)
        $display("FAIL flt_noacc[%0d]: rd=%b wr=%b stall=%b expected 0 0 0",
                 i, bus.mem_read, bus.mem_write, bus.stall);
      else n_pass++;
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      n_checks++;
      if (bus.fault !== ef_t[i] || bus.ld_valid !== 1'b0)
        $display("FAIL flt_pulse[%0d]: fault=%b ld_valid=%b expected %b 0",
                 i, bus.fault, bus.ld_valid, ef_t[i]);
      else n_pass++;
      next_cycle();
      n_checks++;
      if (bus.fault !== 1'b0)
        $display("FAIL flt_clear[%0d]: fault=%b expected 0", i, bus.fault);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) mem[i] = 32'hA0B0C000 + 32'(i);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, LW, 32'(4 * i), 32'd0);
      exp_q.push_back(32'hA0B0C000 + 32'(i));
      @(negedge clk);
      n_checks++;
      if (bus.mem_addr !== 32'(i) || bus.stall !== 1'b0)
        $display("FAIL b2b_addr[%0d]: addr=%0d stall=%b expected %0d 0",
                 i, bus.mem_addr, bus.stall, i);
      else n_pass++;
      next_cycle();
    end
    drive(1'b1, 1'b0, 1'b1, SW, 32'h10, 32'h12345678);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, LW, 32'h10, 32'd0);
    exp_q.push_back(32'h12345678);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (3) next_cycle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    test_reset();
    test_lw_aligned();
    test_extend();
    test_split_load();
    test_store();
    test_reset_in_split();
    test_fault();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL sb_drain: %0d load results never arrived, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
